// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder/subtractor:
// decimal constants, FSM state encoding and a digit-validity helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [1:0] state_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_ADJ  = 4'd6;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic logic bcd_valid(input bcd_digit_t d);
        return (d <= BCD_NINE);
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bus with start/busy/done handshake for bcd_serial_addsub.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic                  cin;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, sub, cin, a, b,
        input  sum, cout, busy, done, err
    );

    modport slave (
        input  start, sub, cin, a, b,
        output sum, cout, busy, done, err
    );
endinterface

// File: rtl/bcd_digit_cell.sv
// Single BCD digit add/subtract cell: nine's-complement select on b,
// binary add with carry-in, then +6 decimal correction.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t a_d,
    input  bcd_digit_t b_d,
    input  logic       sub,
    input  logic       ci,
    output bcd_digit_t s_d,
    output logic       co,
    output logic       bad
);

    bcd_digit_t bd_s;
    logic [4:0] raw_s;

    // Digit arithmetic; invalid digits flow through the same rule.
    always_comb begin
        bd_s  = sub ? (BCD_NINE - b_d) : b_d;
        raw_s = {1'b0, a_d} + {1'b0, bd_s} + {4'b0000, ci};
        if (raw_s > 5'd9) begin
            s_d = raw_s[3:0] + BCD_ADJ;
            co  = 1'b1;
        end else begin
            s_d = raw_s[3:0];
            co  = 1'b0;
        end
        bad = !bcd_valid(a_d) || !bcd_valid(b_d);
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial N-digit packed-BCD adder/subtractor, LSD first, one digit per
// clock through a shared digit cell and a carry flop.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_serial_addsub_if.slave  bus
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [4*DIGITS-1:0] a_r;
    logic [4*DIGITS-1:0] b_r;
    logic                sub_r;
    logic                carry_r;
    logic [4*DIGITS-1:0] sum_r;
    logic                cout_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    bcd_digit_t          a_dig_s;
    bcd_digit_t          b_dig_s;
    bcd_digit_t          s_dig_s;
    logic                co_s;
    logic                bad_s;

    // Select the operand digits addressed by the digit counter.
    always_comb begin
        a_dig_s = 4'(a_r >> {cnt_r, 2'b00});
        b_dig_s = 4'(b_r >> {cnt_r, 2'b00});
    end

    bcd_digit_cell u_cell (
        .a_d (a_dig_s),
        .b_d (b_dig_s),
        .sub (sub_r),
        .ci  (carry_r),
        .s_d (s_dig_s),
        .co  (co_s),
        .bad (bad_s)
    );

    // Control FSM, operand capture and digit-by-digit result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        sub_r   <= bus.sub;
                        // Subtraction uses ten's complement: nine's complement plus one.
                        carry_r <= bus.sub ? ~bus.cin : bus.cin;
                        cnt_r   <= '0;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (cnt_r == CNT_W'(k)) begin
                            sum_r[k*4 +: 4] <= s_dig_s;
                        end
                    end
                    err_r   <= err_r | bad_s;
                    carry_r <= co_s;
                    if (cnt_r == CNT_W'(DIGITS - 1)) begin
                        cout_r  <= co_s;
                        busy_r  <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomized self-checking bench for bcd_serial_addsub against a decimal
// arithmetic reference model.
module tb_bcd_serial_addsub;

    localparam int    D   = 4;
    localparam longint P10 = 64'd10000;

    typedef struct packed {
        logic         err;
        logic         cout;
        logic [4*D-1:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edge_n = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    res_t exp_q[$];
    int   acc_q[$];
    res_t last_r;
    bit   have_last = 1'b0;

    bcd_serial_addsub_if #(.DIGITS(D)) bus ();

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic longint to_dec(input logic [4*D-1:0] v);
        longint r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + longint'(v[k*4 +: 4]);
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input longint n);
        logic [4*D-1:0] r = '0;
        longint m = n;
        for (int k = 0; k < D; k++) begin
            r[k*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Reference: plain decimal arithmetic; digit rule only for illegal digits.
    function automatic res_t model(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                                   input logic s, input logic ci);
        res_t   r;
        bit     bad = 1'b0;
        longint t;
        int     c, raw, ak, bk, bd;
        r = '0;
        for (int k = 0; k < D; k++)
            if (av[k*4 +: 4] > 4'd9 || bv[k*4 +: 4] > 4'd9) bad = 1'b1;
        if (!bad) begin
            if (!s) begin
                t = to_dec(av) + to_dec(bv) + longint'(ci);
                r.cout = (t >= P10);
                r.sum  = to_bcd(t % P10);
            end else begin
                t = to_dec(av) - to_dec(bv) - longint'(ci);
                r.cout = (t >= 0);
                if (t < 0) t = t + P10;
                r.sum = to_bcd(t);
            end
        end else begin
            c = s ? int'(!ci) : int'(ci);
            for (int k = 0; k < D; k++) begin
                ak  = int'(av[k*4 +: 4]);
                bk  = int'(bv[k*4 +: 4]);
                bd  = s ? ((9 - bk) & 15) : bk;
                raw = ak + bd + c;
                if (raw > 9) begin
                    r.sum[k*4 +: 4] = 4'((raw + 6) & 15);
                    c = 1;
                end else begin
                    r.sum[k*4 +: 4] = 4'(raw);
                    c = 0;
                end
            end
            r.cout = (c != 0);
        end
        r.err = bad;
        return r;
    endfunction

    function automatic logic [4*D-1:0] rand_bcd(input bit inv);
        logic [4*D-1:0] r;
        for (int k = 0; k < D; k++) begin
            if (inv && $urandom_range(0, 9) == 0) r[k*4 +: 4] = 4'($urandom_range(10, 15));
            else r[k*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Compare process: every negedge out of reset.
    initial begin
        res_t e;
        int   t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_last = 1'b0;
            end else begin
                chk("busy_done_excl", 64'(bus.busy & bus.done), 64'd0);
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_done", 64'(bus.done), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        t = acc_q.pop_front();
                        chk("sum",     64'(bus.sum),  64'(e.sum));
                        chk("cout",    64'(bus.cout), 64'(e.cout));
                        chk("err",     64'(bus.err),  64'(e.err));
                        chk("latency", 64'(edge_n - t), 64'(D + 1));
                        last_r    = e;
                        have_last = 1'b1;
                    end
                end else if (!bus.busy && exp_q.size() == 0 && have_last) begin
                    chk("hold_sum",  64'(bus.sum),  64'(last_r.sum));
                    chk("hold_cout", 64'(bus.cout), 64'(last_r.cout));
                    chk("hold_err",  64'(bus.err),  64'(last_r.err));
                end
            end
        end
    end

    task automatic issue(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                         input logic sv, input logic cv, input int spur_k);
        bit done_seen = 1'b0;
        bus.a = av; bus.b = bv; bus.sub = sv; bus.cin = cv; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        exp_q.push_back(model(av, bv, sv, cv));
        acc_q.push_back(edge_n);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        for (int k = 0; k <= 3 * D + 4; k++) begin
            @(negedge clk);
            bus.a   = rand_bcd(1'b1);
            bus.b   = rand_bcd(1'b1);
            bus.sub = 1'($urandom_range(0, 1));
            bus.cin = 1'($urandom_range(0, 1));
            bus.start = (k == spur_k);
            #1;
            if (exp_q.size() == 0) begin
                done_seen = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        chk("done_timeout", 64'(done_seen), 64'd1);
        if (!done_seen) begin
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    initial begin
        bit inv;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;

        chk("pin_1234+5678", 64'(model(16'h1234, 16'h5678, 1'b0, 1'b0)), 64'({1'b0, 1'b0, 16'h6912}));
        chk("pin_9999+0001", 64'(model(16'h9999, 16'h0001, 1'b0, 1'b0)), 64'({1'b0, 1'b1, 16'h0000}));
        chk("pin_0+0+c",     64'(model(16'h0000, 16'h0000, 1'b0, 1'b1)), 64'({1'b0, 1'b0, 16'h0001}));
        chk("pin_5000-1234", 64'(model(16'h5000, 16'h1234, 1'b1, 1'b0)), 64'({1'b0, 1'b1, 16'h3766}));
        chk("pin_0123-0456", 64'(model(16'h0123, 16'h0456, 1'b1, 1'b0)), 64'({1'b0, 1'b0, 16'h9667}));
        chk("pin_000A+0001", 64'(model(16'h000A, 16'h0001, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 16'h0011}));
        chk("pin_0-0-b",     64'(model(16'h0000, 16'h0000, 1'b1, 1'b1)), 64'({1'b0, 1'b0, 16'h9999}));

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_sum",  64'(bus.sum),  64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        chk("rst_err",  64'(bus.err),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h5678, 1'b0, 1'b0, -1);
        issue(16'h9999, 16'h0001, 1'b0, 1'b0, -1);
        issue(16'h0000, 16'h0000, 1'b0, 1'b1, -1);
        issue(16'h5000, 16'h1234, 1'b1, 1'b0, -1);
        issue(16'h0123, 16'h0456, 1'b1, 1'b0, -1);
        issue(16'h1234, 16'h5678, 1'b0, 1'b0, 1);
        issue(16'h000A, 16'h0001, 1'b0, 1'b0, -1);
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, -1);
        issue(16'h0000, 16'h0000, 1'b1, 1'b1, -1);
        issue(16'h9999, 16'h9999, 1'b0, 1'b1, D);

        // Abort mid-operation with the digit counter at 2.
        bus.a = 16'h1234; bus.b = 16'h5678; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        have_last = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_sum",  64'(bus.sum),  64'd0);
        chk("abort_cout", 64'(bus.cout), 64'd0);
        chk("abort_err",  64'(bus.err),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'h1234, 16'h5678, 1'b0, 1'b0, -1);

        repeat (80) begin
            inv = ($urandom_range(0, 3) == 0);
            issue(rand_bcd(inv), rand_bcd(inv), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, D)) : -1);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
